// File: rtl/c_encode_binary_v1_0.sv
// Purpose: pipelined priority encoder with no-bit/multi-bit flags and a valid tag.
// Latency: C_PIPE_STAGES enabled CLK edges from D/ND to S/VALID/MULTI/RDY.
// Backpressure: none; CE stalls all stages together, one word per enabled cycle.
module c_encode_binary_v1_0 #(
   parameter int C_IN_WIDTH    = 8,
   parameter int C_SEL_WIDTH   = 3,
   parameter int C_IN_HIGH     = 1,
   parameter int C_PRIORITY    = 0,
   parameter int C_PIPE_STAGES = 1,
   parameter int C_HAS_CE      = 0,
   parameter int C_HAS_SCLR    = 0,
   parameter int C_SYNC_ENABLE = 0
) (
   input  logic                   CLK,
   input  logic                   ACLR,
   input  logic                   CE,
   input  logic                   SCLR,
   input  logic                   ND,
   input  logic [C_IN_WIDTH-1:0]  D,
   output logic [C_SEL_WIDTH-1:0] S,
   output logic                   VALID,
   output logic                   MULTI,
   output logic                   RDY
);

   // Reject configurations the index or pipeline cannot represent.
   if ((1 << C_SEL_WIDTH) < C_IN_WIDTH) begin : g_bad_sel_width
      $error("c_encode_binary_v1_0: C_SEL_WIDTH too small for C_IN_WIDTH");
   end
   if (C_PIPE_STAGES < 1 || C_PIPE_STAGES > 4) begin : g_bad_stages
      $error("c_encode_binary_v1_0: C_PIPE_STAGES must be 1..4");
   end
   if (C_IN_WIDTH < 2 || C_IN_WIDTH > 256) begin : g_bad_width
      $error("c_encode_binary_v1_0: C_IN_WIDTH must be 2..256");
   end

   logic [C_IN_WIDTH-1:0]  x;
   logic [C_SEL_WIDTH-1:0] idx;
   logic                   any;
   logic                   multi;
   logic                   ce_i;
   logic                   sclr_i;
   logic                   clr;

   // Unused control ports collapse to their inactive values.
   assign ce_i   = (C_HAS_CE != 0)   ? CE   : 1'b1;
   assign sclr_i = (C_HAS_SCLR != 0) ? SCLR : 1'b0;
   // With synchronous enable the clear is gated by CE, otherwise it overrides CE.
   assign clr    = (C_SYNC_ENABLE != 0) ? (sclr_i & ce_i) : sclr_i;

   // Active-low inputs are inverted so the encoder always looks for ones.
   assign x = (C_IN_HIGH != 0) ? D : ~D;

   // Single ascending scan: first hit wins for low priority, last hit for high.
   always_comb begin
      idx   = '0;
      any   = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < C_IN_WIDTH; i++) begin
         if (x[i]) begin
            if (C_PRIORITY != 0 || !any) begin
               idx = C_SEL_WIDTH'(i);
            end
            multi = multi | any;
            any   = 1'b1;
         end
      end
   end

   logic [C_SEL_WIDTH-1:0]   s_q [C_PIPE_STAGES];
   logic [C_PIPE_STAGES-1:0] vld_q;
   logic [C_PIPE_STAGES-1:0] mul_q;
   logic [C_PIPE_STAGES-1:0] rdy_q;

   // Shift register of encoded words; ACLR beats SCLR beats CE.
   always_ff @(posedge CLK or posedge ACLR) begin
      if (ACLR) begin
         for (int k = 0; k < C_PIPE_STAGES; k++) begin
            s_q[k] <= '0;
         end
         vld_q <= '0;
         mul_q <= '0;
         rdy_q <= '0;
      end else if (clr) begin
         for (int k = 0; k < C_PIPE_STAGES; k++) begin
            s_q[k] <= '0;
         end
         vld_q <= '0;
         mul_q <= '0;
         rdy_q <= '0;
      end else if (ce_i) begin
         for (int k = C_PIPE_STAGES - 1; k > 0; k--) begin
            s_q[k]   <= s_q[k-1];
            vld_q[k] <= vld_q[k-1];
            mul_q[k] <= mul_q[k-1];
            rdy_q[k] <= rdy_q[k-1];
         end
         s_q[0]   <= idx;
         vld_q[0] <= any;
         mul_q[0] <= multi;
         rdy_q[0] <= ND;
      end
   end

   assign S     = s_q[C_PIPE_STAGES-1];
   assign VALID = vld_q[C_PIPE_STAGES-1];
   assign MULTI = mul_q[C_PIPE_STAGES-1];
   assign RDY   = rdy_q[C_PIPE_STAGES-1];

endmodule

// File: tb/tb_c_encode_binary_v1_0.sv
// Directed bench for c_encode_binary_v1_0 across several parameter sets.
// Six instances share the inputs; each step checks only the relevant instance.
// Expected words are packed as {RDY, S, VALID, MULTI}.
module tb_c_encode_binary_v1_0;

   logic       clk;
   logic       aclr;
   logic       ce;
   logic       sclr;
   logic       nd;
   logic [7:0] d;

   logic [2:0] s_a, s_b, s_c, s_d, s_e, s_f;
   logic       v_a, v_b, v_c, v_d, v_e, v_f;
   logic       m_a, m_b, m_c, m_d, m_e, m_f;
   logic       r_a, r_b, r_c, r_d, r_e, r_f;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Defaults
   c_encode_binary_v1_0 u_a (
      .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .ND(nd), .D(d),
      .S(s_a), .VALID(v_a), .MULTI(m_a), .RDY(r_a));

   // Highest wins, three stages
   c_encode_binary_v1_0 #(.C_PRIORITY(1), .C_PIPE_STAGES(3)) u_b (
      .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .ND(nd), .D(d),
      .S(s_b), .VALID(v_b), .MULTI(m_b), .RDY(r_b));

   // Active-low inputs
   c_encode_binary_v1_0 #(.C_IN_HIGH(0)) u_c (
      .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .ND(nd), .D(d),
      .S(s_c), .VALID(v_c), .MULTI(m_c), .RDY(r_c));

   // Two stages with clock enable
   c_encode_binary_v1_0 #(.C_PIPE_STAGES(2), .C_HAS_CE(1)) u_d (
      .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .ND(nd), .D(d),
      .S(s_d), .VALID(v_d), .MULTI(m_d), .RDY(r_d));

   // SCLR overrides CE
   c_encode_binary_v1_0 #(.C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(0)) u_e (
      .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .ND(nd), .D(d),
      .S(s_e), .VALID(v_e), .MULTI(m_e), .RDY(r_e));

   // SCLR gated by CE
   c_encode_binary_v1_0 #(.C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(1)) u_f (
      .CLK(clk), .ACLR(aclr), .CE(ce), .SCLR(sclr), .ND(nd), .D(d),
      .S(s_f), .VALID(v_f), .MULTI(m_f), .RDY(r_f));

   function automatic logic [5:0] pk(input logic r, input logic [2:0] s,
                                     input logic v, input logic m);
      return {r, s, v, m};
   endfunction

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed {rdy,s,valid,multi}=%b required=%b", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      aclr = 1'b1;
      ce   = 1'b1;
      sclr = 1'b0;
      nd   = 1'b0;
      d    = 8'h00;
      #2;
      chk("reset_a", pk(r_a, s_a, v_a, m_a), pk(1'b0, 3'd0, 1'b0, 1'b0));
      chk("reset_b", pk(r_b, s_b, v_b, m_b), pk(1'b0, 3'd0, 1'b0, 1'b0));
      tick();
      aclr = 1'b0;

      // Edge 1: 0010_0100, lowest-first picks bit 2
      nd = 1'b1; d = 8'h24;
      tick();
      chk("e1_a_24", pk(r_a, s_a, v_a, m_a), pk(1'b1, 3'd2, 1'b1, 1'b1));
      chk("e1_b_rdy0", {5'b0, r_b}, 6'd0);

      // Edge 2: single bit 7
      d = 8'h80;
      tick();
      chk("e2_a_80", pk(r_a, s_a, v_a, m_a), pk(1'b1, 3'd7, 1'b1, 1'b0));
      chk("e2_b_rdy0", {5'b0, r_b}, 6'd0);

      // Edge 3: ND=0, no bits
      nd = 1'b0; d = 8'h00;
      tick();
      chk("e3_a_none", pk(r_a, s_a, v_a, m_a), pk(1'b0, 3'd0, 1'b0, 1'b0));
      chk("e3_b_24_hi", pk(r_b, s_b, v_b, m_b), pk(1'b1, 3'd5, 1'b1, 1'b1));

      // Edge 4: all ones
      nd = 1'b1; d = 8'hFF;
      tick();
      chk("e4_a_ff", pk(r_a, s_a, v_a, m_a), pk(1'b1, 3'd0, 1'b1, 1'b1));
      chk("e4_b_80_hi", pk(r_b, s_b, v_b, m_b), pk(1'b1, 3'd7, 1'b1, 1'b0));
      chk("e4_c_ff_low", pk(r_c, s_c, v_c, m_c), pk(1'b1, 3'd0, 1'b0, 1'b0));

      // Edge 5: active-low bit 4 only
      d = 8'hEF;
      tick();
      chk("e5_c_ef_low", pk(r_c, s_c, v_c, m_c), pk(1'b1, 3'd4, 1'b1, 1'b0));
      chk("e5_b_nd0_word", pk(r_b, s_b, v_b, m_b), pk(1'b0, 3'd0, 1'b0, 1'b0));

      // CE stream on the two-stage instance
      d = 8'h01; ce = 1'b1;
      tick();                                   // edge 6 loads 01
      d = 8'h02; ce = 1'b0;
      tick();                                   // edge 7 holds (EF word still out)
      chk("ce_hold", pk(r_d, s_d, v_d, m_d), pk(1'b1, 3'd0, 1'b1, 1'b1));
      ce = 1'b1;
      tick();                                   // edge 8 loads 02
      chk("ce_w0", pk(r_d, s_d, v_d, m_d), pk(1'b1, 3'd0, 1'b1, 1'b0));
      d = 8'h04;
      tick();
      chk("ce_w1", pk(r_d, s_d, v_d, m_d), pk(1'b1, 3'd1, 1'b1, 1'b0));
      d = 8'h08;
      tick();
      chk("ce_w2", pk(r_d, s_d, v_d, m_d), pk(1'b1, 3'd2, 1'b1, 1'b0));
      nd = 1'b0; d = 8'h00;
      tick();
      chk("ce_w3", pk(r_d, s_d, v_d, m_d), pk(1'b1, 3'd3, 1'b1, 1'b0));
      tick();
      chk("ce_drain", pk(r_d, s_d, v_d, m_d), pk(1'b0, 3'd0, 1'b0, 1'b0));

      // ACLR with words in flight on the three-stage instance
      nd = 1'b1; d = 8'h03;
      tick();
      d = 8'h0C;
      tick();
      d = 8'hC0;
      tick();                                   // 03 now at the output
      chk("pre_aclr_b", pk(r_b, s_b, v_b, m_b), pk(1'b1, 3'd1, 1'b1, 1'b1));
      #2;
      aclr = 1'b1;
      #1;
      chk("aclr_async_b", pk(r_b, s_b, v_b, m_b), pk(1'b0, 3'd0, 1'b0, 1'b0));
      tick();
      chk("aclr_held_b", pk(r_b, s_b, v_b, m_b), pk(1'b0, 3'd0, 1'b0, 1'b0));
      aclr = 1'b0;
      d = 8'h30;
      tick();                                   // 30 enters stage 1
      chk("post_aclr_e1", pk(r_b, s_b, v_b, m_b), pk(1'b0, 3'd0, 1'b0, 1'b0));
      nd = 1'b0; d = 8'h00;
      tick();
      chk("post_aclr_e2", pk(r_b, s_b, v_b, m_b), pk(1'b0, 3'd0, 1'b0, 1'b0));
      tick();
      chk("post_aclr_e3", pk(r_b, s_b, v_b, m_b), pk(1'b1, 3'd5, 1'b1, 1'b1));

      // SCLR with CE low, then high
      nd = 1'b1; d = 8'h10; ce = 1'b1;
      tick();
      chk("sclr_pre_e", pk(r_e, s_e, v_e, m_e), pk(1'b1, 3'd4, 1'b1, 1'b0));
      chk("sclr_pre_f", pk(r_f, s_f, v_f, m_f), pk(1'b1, 3'd4, 1'b1, 1'b0));
      sclr = 1'b1; ce = 1'b0; d = 8'h01;
      tick();
      chk("sclr_ce0_async", pk(r_e, s_e, v_e, m_e), pk(1'b0, 3'd0, 1'b0, 1'b0));
      chk("sclr_ce0_sync", pk(r_f, s_f, v_f, m_f), pk(1'b1, 3'd4, 1'b1, 1'b0));
      ce = 1'b1;
      tick();
      chk("sclr_ce1_sync", pk(r_f, s_f, v_f, m_f), pk(1'b0, 3'd0, 1'b0, 1'b0));
      sclr = 1'b0; d = 8'h06;
      tick();
      chk("sclr_release_f", pk(r_f, s_f, v_f, m_f), pk(1'b1, 3'd1, 1'b1, 1'b1));
      chk("sclr_release_e", pk(r_e, s_e, v_e, m_e), pk(1'b1, 3'd1, 1'b1, 1'b1));
      nd = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/c_encode_binary_v1_0.md
Name: c_encode_binary_v1_0

Overview:
- Pipelined priority encoder: one-hot/multi-hot input word in, binary index out.
- The inverse of the team's binary decoder.
- Used on arbitration grant vectors and flag words ahead of binary-indexed muxes and counters.
- Flags no-bit-set and multiple-bits-set; carries an input-valid tag through the same pipeline.

Parameters:
C_IN_WIDTH, 8, number of input lines (2..256)
C_SEL_WIDTH, 3, output index width; elaboration error if 2**C_SEL_WIDTH < C_IN_WIDTH
C_IN_HIGH, 1, 1 = asserted input bit is 1; 0 = asserted input bit is 0 (D inverted before encode)
C_PRIORITY, 0, 0 = lowest asserted index wins; 1 = highest asserted index wins
C_PIPE_STAGES, 1, register stages from D to outputs (1..4)
C_HAS_CE, 0, 1 = CE port used; 0 = CE treated as 1
C_HAS_SCLR, 0, 1 = SCLR port used; 0 = SCLR treated as 0
C_SYNC_ENABLE, 0, 0 = SCLR overrides CE; 1 = SCLR acts only when CE=1

Ports:
CLK  in  1  rising-edge clock
ACLR  in  1  asynchronous active-high reset; clears every pipeline stage
CE  in  1  clock enable; all stages advance together only when CE=1
SCLR  in  1  synchronous clear of all stages
ND  in  1  new data: D is valid this cycle
D  in  C_IN_WIDTH  input line vector
S  out  C_SEL_WIDTH  encoded index of the winning line
VALID  out  1  at least one line was asserted
MULTI  out  1  more than one line was asserted
RDY  out  1  delayed ND: S/VALID/MULTI correspond to an ND=1 sample

Behaviour:
- Stage 0 (combinational):
  - x = D if C_IN_HIGH=1, else ~D.
  - idx = lowest set bit of x (C_PRIORITY=0) or highest set bit (C_PRIORITY=1).
  - any = |x.
  - multi = popcount(x) >= 2.
  - No bit set: idx=0, any=0, multi=0.
- Pipeline:
  - C_PIPE_STAGES registers, each holding {ND, idx, any, multi}.
  - On a rising CLK with CE=1, stage k loads stage k-1; stage 1 loads stage 0.
  - With CE=0 all stages hold.
  - Outputs {RDY, S, VALID, MULTI} are the last stage.
- Latency: exactly C_PIPE_STAGES enabled clock edges from D/ND sampled to the outputs.
- Throughput: one word per enabled cycle, no bubbles.
- ND=0 words still propagate. Their RDY is 0; S/VALID/MULTI are the encode of whatever D held (not forced to 0).
- ACLR=1, at any time and immediately (asynchronously):
  - All stages cleared: RDY=0, S=0, VALID=0, MULTI=0.
  - In-flight words discarded.
  - Outputs stay 0 while ACLR is held.
  - First enabled edge after ACLR falls loads stage 1 normally.
- Reset values of outputs: S=0, VALID=0, MULTI=0, RDY=0.
- SCLR=1 at an edge:
  - C_SYNC_ENABLE=0: all stages cleared regardless of CE.
  - C_SYNC_ENABLE=1: all stages cleared only if CE=1, otherwise hold.
  - The word presented on D that cycle is discarded.
- Priority: ACLR > SCLR > CE > data.
- Index width: idx zero-extended to C_SEL_WIDTH when C_SEL_WIDTH > ceil(log2(C_IN_WIDTH)).
- Simulation X handling:
  - Any D bit X/Z with ND=1: that word's S, VALID and MULTI are all X.
  - CE=X at a rising edge: each stage bit that would change becomes X; bits that would not change hold.
  - CLK transition 0->X or X->1 is treated as a possible edge, same rule as CE=X.

Test Plan:
1. Defaults, ACLR pulse, then ND=1, D=8'b0010_0100, CE=1 -> one edge later S=2, VALID=1, MULTI=1, RDY=1.
2. C_PRIORITY=1, C_PIPE_STAGES=3, ND=1, D=8'b0010_0100 -> S=5, VALID=1, MULTI=1, RDY=1 on the 3rd edge; RDY=0 on edges 1-2.
3. C_IN_HIGH=0, D=8'hFF, ND=1 -> S=0, VALID=0, MULTI=0, RDY=1; then D=8'hEF -> S=4, VALID=1, MULTI=0.
4. C_PIPE_STAGES=2, C_HAS_CE=1: stream D=01,02,04,08 with ND=1, CE=0 on the 2nd cycle -> outputs S=0,1,2,3 in order, each RDY=1, with one held cycle and no loss or duplication.
5. C_PIPE_STAGES=3 with words in flight, ACLR asserted between edges -> all outputs 0 before the next edge; after release only newly entered words emerge.
6. C_HAS_SCLR=1, C_HAS_CE=1, SCLR=1 with CE=0 -> C_SYNC_ENABLE=0: outputs cleared at the edge; C_SYNC_ENABLE=1: outputs hold previous S/RDY.
